// File: rtl/uart_char_rx.sv
// 8N1 asynchronous serial receiver: a two-flop synchronizer feeds a mid-bit sampling FSM.
// It emits each good byte with a one-cycle valid strobe and flags bad stop bits.
module uart_char_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_s1_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      rx_s1_q     <= rx;
      rx_s_q      <= rx_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Re-check the start bit at its midpoint; a high here was only a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            out_d       = shift_q;
            out_valid_d = 1'b1;
            state_d     = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        // Hold off until the line idles so a break is not read as 0x00 frames.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed plus randomized bench for uart_char_rx; a frame-level model predicts the
// character stream, error pulses and strobe latency, and a monitor collects DUT strobes.
module tb_uart_char_rx;

  localparam int N  = 16;
  localparam int N8 = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx8 = 1'b1;
  logic [7:0] out, out8;
  logic       out_valid, frame_err, out_valid8, frame_err8;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_char_rx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .out      (out),
    .out_valid(out_valid),
    .frame_err(frame_err)
  );

  uart_char_rx #(.CLKS_PER_BIT(N8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx8),
    .out      (out8),
    .out_valid(out_valid8),
    .frame_err(frame_err8)
  );

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [7:0] rxq[$];
  logic [7:0] rxq8[$];
  int         fe_cnt = 0, fe_cnt8 = 0, stab_err = 0, overlap = 0;
  int         last_cyc = 0, last_cyc8 = 0;
  logic [7:0] out_at_fe = 8'h00, prev_out = 8'h00;
  logic       rst_prev = 1'b1;

  always @(negedge clk) begin
    if (out_valid) begin
      rxq.push_back(out);
      last_cyc = cyc;
    end
    if (frame_err) begin
      fe_cnt++;
      out_at_fe = out;
    end
    if (out_valid && frame_err) overlap++;
    if (!out_valid && !rst_prev && out !== prev_out) stab_err++;
    prev_out = out;
    rst_prev = reset;
    if (out_valid8) begin
      rxq8.push_back(out8);
      last_cyc8 = cyc;
    end
    if (frame_err8) fe_cnt8++;
  end

  // Reference model: expected character stream, error count and visible out value.
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  logic [7:0] exp_out = 8'h00;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] got(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  // Drive one frame: start, 8 data bits LSB first, one stop bit; the line is left at the stop level.
  task automatic send(input bit sel8, input logic [7:0] b, input logic stop_bit, input int n);
    if (sel8) rx8 = 1'b0; else rx = 1'b0;
    tick(n);
    for (int i = 0; i < 8; i++) begin
      if (sel8) rx8 = b[i]; else rx = b[i];
      tick(n);
    end
    if (sel8) rx8 = stop_bit; else rx = stop_bit;
    tick(n);
    if (!sel8) begin
      if (stop_bit) begin
        exp_q.push_back(b);
        exp_out = b;
      end else begin
        exp_fe++;
      end
    end
  endtask

  task automatic compare_all(input string tag, input int base);
    check({tag, "_count"}, rxq.size(), exp_q.size());
    for (int i = base; i < exp_q.size(); i++) check($sformatf("%s_char%0d", tag, i), got(i), exp_q[i]);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_fe"}, fe_cnt, exp_fe);
  endtask

  initial begin
    int s;
    int base;
    logic [7:0] b;
    logic [7:0] str[9];
    str = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20, 8'h65, 8'h6E, 8'h64};

    // Reset values.
    tick(3);
    check("rst_out", out, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    tick(2);

    // Single character with latency measured from the first drive of the start bit.
    s = cyc;
    send(1'b0, 8'h62, 1'b1, N);
    tick(2);
    compare_all("single", 0);
    check("single_latency", last_cyc - s, N / 2 + 9 * N + 3);

    // Back-to-back string, no idle gap.
    base = rxq.size();
    for (int i = 0; i < 9; i++) send(1'b0, str[i], 1'b1, N);
    tick(4);
    compare_all("string", base);

    // Random characters with random short idle gaps.
    base = rxq.size();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send(1'b0, b, 1'b1, N);
      tick($urandom_range(0, 3));
    end
    tick(4);
    compare_all("random", base);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(300);
    compare_all("glitch", rxq.size());

    // Framing error, line held low, then a good frame.
    base = rxq.size();
    send(1'b0, 8'h65, 1'b0, N);
    tick(40);
    rx = 1'b1;
    tick(2 * N);
    check("ferr_out_at_pulse", out_at_fe, exp_out);
    compare_all("ferr", base);
    send(1'b0, 8'h6E, 1'b1, N);
    tick(4);
    compare_all("after_ferr", base);

    // Reset after 4 data bits of 0x44; the line stays low into the next frame's start bit.
    base = rxq.size();
    b = 8'h44;
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(N);
    end
    reset = 1'b1;
    rx = 1'b0;
    tick(1);
    reset = 1'b0;
    exp_out = 8'h00;
    check("midrst_out", out, exp_out);
    check("midrst_nostrobe", rxq.size(), base);
    send(1'b0, 8'h64, 1'b1, N);
    tick(4);
    compare_all("midrst", base);

    // Second instance with 8 clocks per bit.
    s = cyc;
    send(1'b1, 8'h4E, 1'b1, N8);
    tick(2);
    check("n8_count", rxq8.size(), 1);
    check("n8_char", (rxq8.size() > 0) ? rxq8[0] : 8'hxx, 8'h4E);
    check("n8_latency", last_cyc8 - s, N8 / 2 + 9 * N8 + 3);
    check("n8_fe", fe_cnt8, 0);

    check("out_stability", stab_err, 0);
    check("strobe_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_char_rx.md
# uart_char_rx

Serial front end for the character-checking datapath. It receives 8N1 asynchronous serial frames on a single line and presents each decoded ASCII byte as an 8-bit character with a one-cycle valid strobe. It sits directly upstream of the keyword/block checker, which samples `out` whenever `out_valid` is high. Frames with a bad stop bit are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `rx` input 1: asynchronous serial line. Idle level is 1.
- `out` output 8: last correctly received character. Held stable between strobes.
- `out_valid` output 1: one-cycle pulse when `out` has just been updated.
- `frame_err` output 1: one-cycle pulse when a frame's stop bit samples 0.

## Operation
- **Synchronizer**
  - `rx` passes through two flops, `rx_s1` then `rx_s`. Both reset to 1.
  - The FSM sees only `rx_s`, which lags `rx` by 2 cycles.
- **Counters**
  - `cnt` is a cycle counter of width ceil(log2(CLKS_PER_BIT)).
  - `bit_idx` is 3 bits.
  - `shift` is an 8-bit register filled LSB first.
  - Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** if `rx_s`==0, go to START with `cnt`=0.
  - **START:** count up. When `cnt`==H-1, sample `rx_s`.
    - If 0: go to DATA with `cnt`=0 and `bit_idx`=0.
    - If 1: treat as a glitch and return to IDLE with no output.
  - **DATA:** count up. When `cnt`==N-1:
    - Set `shift[bit_idx]` = `rx_s` and clear `cnt`.
    - If `bit_idx`==7, go to STOP. Otherwise increment `bit_idx`.
  - **STOP:** count up. When `cnt`==N-1, sample `rx_s`.
    - If 1: load `out` with `shift`, pulse `out_valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `out` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as frames of 0x00.
- `out_valid` and `frame_err` are never high in the same cycle.
- No internal buffering. A downstream stage that misses a strobe loses that character.

## Timing
- **Reset values:** `out`=8'h00, `out_valid`=0, `frame_err`=0. State is IDLE, counters are 0, sync flops are 1.
- **Frame timeline.** Cycle 0 is the IDLE cycle in which `rx_s`==0 is first seen.
  - Start bit is checked in cycle H.
  - Data bit i is sampled in cycle H+(i+1)·N.
  - Stop bit is sampled in cycle H+9N.
  - `out_valid` (or `frame_err`) is high in cycle H+9N+1.
- **Latency:** from the first clock edge at which `rx` is registered low, the strobe arrives after H+9N+3 cycles. For N=16 that is 155 cycles.
- **Back-to-back frames:** the cycle after the stop sample is IDLE. A start edge arriving right after a 1-bit stop is accepted with no lost character.
- **Glitch rejection:** a low pulse on `rx_s` shorter than H cycles never leaves START. No outputs are produced.
- **Reset mid-frame:** takes effect at the next edge.
  - The partial frame is discarded and no strobe is produced.
  - `out` returns to 8'h00.
  - If the line is still low after reset, the FSM starts a new frame from IDLE. A following well-formed frame decodes correctly.
- **Outputs and stability:** all outputs are registered with no combinational path from `rx`. `out` changes only in the strobe cycle.

## Test plan
- **Single character:** with N=16, reset, then send 0x62 ('b') at 16 clk/bit → `out`=8'h62 with `out_valid` high for exactly 1 cycle, 155 cycles after the start edge. `frame_err` stays 0.
- **Back-to-back string:** send "begin end" as consecutive frames with 1 stop bit and no idle gap → 9 strobes in order with `out` = 62,65,67,69,6E,20,65,6E,64.
- **Glitch:** drive `rx` low for 5 cycles, then high for 300 cycles → no `out_valid`, no `frame_err`, `out` unchanged.
- **Framing error:** send 0x65 with stop bit 0, hold the line low for 40 cycles, release, then send 0x6E → one `frame_err` pulse and `out` still equal to the previous value. Then exactly one `out_valid` with `out`=8'h6E.
- **Reset mid-frame:** assert `reset` for 1 cycle after 4 data bits of 0x44 → no strobe for that frame and `out`=8'h00. The next frame 0x64 yields `out`=8'h64.
- **Parameter check:** N=8 and send 0x4E ('N') → strobe 4+72+1 = 77 cycles after IDLE sees the start bit, with `out`=8'h4E.
